// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period of a slow asynchronous clock in MASTER_CLK cycles.
// Define PERIOD_AVG4_EN to average over four consecutive periods instead of one.
module clk_period_meter #(
    parameter int              CNT_W       = 33,
    parameter longint unsigned TIMEOUT_CYC = 64'd4294967296
) (
    input  logic             MASTER_CLK,
    input  logic             RST_N,
    input  logic             MEAS_CLK_IN,
    input  logic             START,
    output logic             BUSY,
    output logic             VALID,
    output logic [CNT_W-1:0] PERIOD,
    output logic             TIMEOUT_ERR
);
    localparam int             TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  WT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {IDLE, ARM, COUNT, DONE, TOUT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       rst_sync_q;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    wt_q, wt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             busy_q, valid_q, tout_q;
    logic             rise;
    logic             rst_int_n;

`ifdef PERIOD_AVG4_EN
    localparam int SW = CNT_W + 2;
    logic [SW-1:0] sum_q, sum_d, tot;
    logic [1:0]    edg_q, edg_d;
`endif

    // Reset asserts asynchronously but is released in step with MASTER_CLK
    always_ff @(posedge MASTER_CLK or negedge RST_N) begin
        if (!RST_N) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];
    assign rise      = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wt_d     = wt_q;
        period_d = period_q;
`ifdef PERIOD_AVG4_EN
        sum_d    = sum_q;
        edg_d    = edg_q;
        tot      = sum_q + SW'(cnt_q);
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = ARM;
                    wt_d    = '0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                    wt_d    = '0;
`ifdef PERIOD_AVG4_EN
                    sum_d   = '0;
                    edg_d   = '0;
`endif
                end else if (wt_q == WT_LAST) begin
                    state_d = TOUT;
                end else begin
                    wt_d = wt_q + TW'(1);
                end
            end
            COUNT: begin
                if (rise) begin
`ifdef PERIOD_AVG4_EN
                    if (edg_q == 2'd3) begin
                        period_d = CNT_W'(tot >> 2);
                        state_d  = DONE;
                    end else begin
                        sum_d = tot;
                        edg_d = edg_q + 2'd1;
                        cnt_d = CNT_W'(1);
                        wt_d  = '0;
                    end
`else
                    period_d = cnt_q;
                    state_d  = DONE;
`endif
                end else if (wt_q == WT_LAST) begin
                    state_d = TOUT;
                end else begin
                    wt_d  = wt_q + TW'(1);
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            TOUT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MASTER_CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            wt_q     <= '0;
            period_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[1:0], MEAS_CLK_IN};
            cnt_q    <= cnt_d;
            wt_q     <= wt_d;
            period_q <= period_d;
            busy_q   <= state_d != IDLE;
            valid_q  <= state_d == DONE;
            tout_q   <= state_d == TOUT;
        end
    end

`ifdef PERIOD_AVG4_EN
    always_ff @(posedge MASTER_CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sum_q <= '0;
            edg_q <= '0;
        end else begin
            sum_q <= sum_d;
            edg_q <= edg_d;
        end
    end
`endif

    assign BUSY        = busy_q;
    assign VALID       = valid_q;
    assign PERIOD      = period_q;
    assign TIMEOUT_ERR = tout_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed scoreboard bench for clk_period_meter.
module tb_clk_period_meter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start_t, gen_en, gen_val, man_val, meas;
    logic        busy, valid, tout, busy_t, valid_t, tout_t;
    logic [32:0] period, period_t;
    int          hi_len = 5, lo_len = 5;
    int          n_cmp = 0, n_bad = 0, vcount = 0, tcount = 0;
    logic [32:0] exp_q[$];

    assign meas = gen_en ? gen_val : man_val;

    clk_period_meter #(.CNT_W(33), .TIMEOUT_CYC(64'd4096)) dut (
        .MASTER_CLK(clk), .RST_N(rst_n), .MEAS_CLK_IN(meas), .START(start),
        .BUSY(busy), .VALID(valid), .PERIOD(period), .TIMEOUT_ERR(tout));

    clk_period_meter #(.CNT_W(33), .TIMEOUT_CYC(64'd64)) dut_t (
        .MASTER_CLK(clk), .RST_N(rst_n), .MEAS_CLK_IN(meas), .START(start_t),
        .BUSY(busy_t), .VALID(valid_t), .PERIOD(period_t), .TIMEOUT_ERR(tout_t));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int lim, input string tag);
        int k = 0;
        while (!valid && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, valid, 1);
    endtask

    task automatic per(input int n);
        man_val = 1'b1;
        cyc(n / 2);
        man_val = 1'b0;
        cyc(n - n / 2);
    endtask

    initial begin
        gen_val = 1'b0;
        forever begin
            gen_val = 1'b1;
            repeat (hi_len) @(negedge clk);
            gen_val = 1'b0;
            repeat (lo_len) @(negedge clk);
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            vcount++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_unexpected_valid: observed VALID with empty queue, expected no VALID");
            end
            if (exp_q.size() != 0) chk("sb_period", period, exp_q.pop_front());
        end
        if (tout) tcount++;
    end

    initial begin
        int k, v0, t0, vt;
        rst_n = 1'b0; start = 1'b0; start_t = 1'b0; gen_en = 1'b1; man_val = 1'b0;
        cyc(10);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_tout", tout, 0);
        chk("rst_period", period, 0);
        rst_n = 1'b1;
        cyc(5);
        chk("idle_busy", busy, 0);
        chk("idle_period", period, 0);

        exp_q.push_back(33'd10);
        pulse_start();
        chk("start_busy", busy, 1);
        wait_valid(200, "basic_valid");
        chk("done_busy", busy, 1);
        cyc(1);
        chk("post_busy", busy, 0);
        chk("post_valid", valid, 0);

        hi_len = 3; lo_len = 1000;
        exp_q.push_back(33'd1003);
        pulse_start();
        wait_valid(8000, "asym_valid");
        cyc(1);

        hi_len = 50; lo_len = 50;
        exp_q.push_back(33'd100);
        pulse_start();
        wait_valid(8000, "p100_valid");
        cyc(1);

        exp_q.push_back(33'd100);
        v0 = vcount;
        pulse_start();
        cyc(3);
        pulse_start();
        wait_valid(2000, "busy_valid");
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("done_start_busy", busy, 0);
        cyc(700);
        chk("single_valid", vcount, v0 + 1);
        chk("ignored_busy", busy, 0);

        pulse_start();
        k = 0;
        while (meas && k < 200) begin cyc(1); k++; end
        while (!meas && k < 200) begin cyc(1); k++; end
        cyc(20);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        cyc(1);
        chk("rstm_busy", busy, 0);
        chk("rstm_valid", valid, 0);
        chk("rstm_period", period, 0);
        v0 = vcount; t0 = tcount;
        cyc(3);
        rst_n = 1'b1;
        cyc(700);
        chk("rstm_no_valid", vcount, v0);
        chk("rstm_no_tout", tcount, t0);
        chk("rstm_idle", busy, 0);

        hi_len = 5; lo_len = 5;
        cyc(20);
        start_t = 1'b1;
        cyc(1);
        start_t = 1'b0;
        k = 0;
        while (!valid_t && k < 200) begin cyc(1); k++; end
        chk("t_valid", valid_t, 1);
        chk("t_period", period_t, 10);
        cyc(2);
        gen_en = 1'b0;
        man_val = 1'b0;
        cyc(10);
        start_t = 1'b1;
        cyc(1);
        start_t = 1'b0;
        k = 0; vt = 0;
        while (!tout_t && k < 200) begin
            cyc(1);
            k++;
            if (valid_t) vt++;
        end
        chk("to_cycles", k, 64);
        chk("to_flag", tout_t, 1);
        chk("to_busy", busy_t, 1);
        chk("to_no_valid", vt, 0);
        chk("to_period_kept", period_t, 10);
        cyc(1);
        chk("to_busy_drop", busy_t, 0);
        chk("to_pulse_end", tout_t, 0);

`ifdef PERIOD_AVG4_EN
        exp_q.push_back(33'd11);
        pulse_start();
        cyc(5);
        per(10); per(10); per(12); per(12);
        man_val = 1'b1;
        wait_valid(50, "avg11_valid");
        cyc(1);
        man_val = 1'b0;
        cyc(5);
        exp_q.push_back(33'd10);
        pulse_start();
        cyc(5);
        per(10); per(10); per(10); per(11);
        man_val = 1'b1;
        wait_valid(50, "avg10_valid");
        cyc(1);
        man_val = 1'b0;
        cyc(5);
`endif

        chk("sb_drained", exp_q.size(), 0);
        chk("no_tout_main", tcount, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
